// File: rtl/light_pkg.sv
// Shared definitions for the traffic-light controller and its phase timer:
// phase encoding, default phase durations and the default tick divider.
package light_pkg;

    localparam logic [1:0] Red    = 2'b00;
    localparam logic [1:0] Green  = 2'b01;
    localparam logic [1:0] Yellow = 2'b10;

    localparam int RED_TIME    = 6;
    localparam int GREEN_TIME  = 4;
    localparam int YELLOW_TIME = 2;
    localparam int TICK_DIV    = 50000000;

    function automatic logic one_hot3(input logic r, input logic g, input logic y);
        logic result;
        case ({r, g, y})
            3'b100, 3'b010, 3'b001: result = 1'b1;
            default:                result = 1'b0;
        endcase
        return result;
    endfunction

    // Only meaningful when the lamps are one-hot; callers gate on one_hot3.
    function automatic logic [1:0] encode_phase(input logic r, input logic g, input logic y);
        logic [1:0] result;
        case ({r, g, y})
            3'b100:  result = Red;
            3'b010:  result = Green;
            3'b001:  result = Yellow;
            default: result = 2'b11;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick pulse every TICK_DIV clocks;
// clr restarts the period so a new phase always begins with a full tick interval.
module tick_prescaler #(
    parameter int TICK_DIV = light_pkg::TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] prescaler;

    // Prescaler count and registered tick pulse; clr wins over a wrap in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            tick      <= 1'b0;
        end else if (clr) begin
            prescaler <= '0;
            tick      <= 1'b0;
        end else if (prescaler == LAST) begin
            prescaler <= '0;
            tick      <= 1'b1;
        end else begin
            prescaler <= prescaler + PW'(1);
            tick      <= 1'b0;
        end
    end

endmodule

// File: rtl/phase_timer.sv
// Phase timer for the traffic-light controller: counts ticks in the current phase
// and flags expiry per lamp. Optional countdown output under PHASE_TIMER_REMAIN_EN.
module phase_timer #(
    parameter int TICK_DIV    = light_pkg::TICK_DIV,
    parameter int CNT_W       = 4,
    parameter int RED_TIME    = light_pkg::RED_TIME,
    parameter int GREEN_TIME  = light_pkg::GREEN_TIME,
    parameter int YELLOW_TIME = light_pkg::YELLOW_TIME
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             red,
    input  logic             green,
    input  logic             yellow,
    input  logic             clr,
    output logic             max_r,
    output logic             max_g,
    output logic             max_y,
    output logic             tick,
    output logic             phase_err
`ifdef PHASE_TIMER_REMAIN_EN
    ,
    output logic [CNT_W-1:0] remain
`endif
);

    import light_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] RED_T   = CNT_W'(RED_TIME);
    localparam logic [CNT_W-1:0] GREEN_T = CNT_W'(GREEN_TIME);
    localparam logic [CNT_W-1:0] YEL_T   = CNT_W'(YELLOW_TIME);

    logic [CNT_W-1:0] count;
    logic             legal;

    assign legal = one_hot3(red, green, yellow);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    // Elapsed-tick counter, saturating so a held phase never appears to restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= count;
        end
    end

    // One-cycle-delayed, non-sticky illegal-phase flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_err <= 1'b0;
        end else begin
            phase_err <= ~legal;
        end
    end

    // Expiry decode; clr masks the stale count left over from the previous phase.
    always_comb begin
        max_r = 1'b0;
        max_g = 1'b0;
        max_y = 1'b0;
        if (legal && !clr) begin
            max_r = red    && (count >= RED_T);
            max_g = green  && (count >= GREEN_T);
            max_y = yellow && (count >= YEL_T);
        end else begin
            max_r = 1'b0;
            max_g = 1'b0;
            max_y = 1'b0;
        end
    end

`ifdef PHASE_TIMER_REMAIN_EN
    logic [CNT_W-1:0] sel_time;

    // Countdown for the display: selected duration minus elapsed ticks, floored at zero.
    always_comb begin
        sel_time = '0;
        remain   = '0;
        case (encode_phase(red, green, yellow))
            Red:     sel_time = RED_T;
            Green:   sel_time = GREEN_T;
            Yellow:  sel_time = YEL_T;
            default: sel_time = '0;
        endcase
        if (legal && !clr && (sel_time > count)) begin
            remain = sel_time - count;
        end else begin
            remain = '0;
        end
    end
`endif

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer (TICK_DIV=4): directed scenarios plus random
// phase/clr/reset traffic, checked against an age-since-clear reference model.
module tb_phase_timer;

    localparam int TD = 4;
    localparam int CW = 4;
    localparam int RT = 6;
    localparam int GT = 4;
    localparam int YT = 2;

    logic clk = 1'b0;
    logic reset, red, green, yellow, clr;
    logic max_r, max_g, max_y, tick, phase_err;
    logic [4:0] obs;
    logic [4:0] e;
`ifdef PHASE_TIMER_REMAIN_EN
    logic [CW-1:0] remain;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    // Model: cycles since the last clr/reset edge, and the expected error flag.
    int m_age = 0;
    int m_err = 0;

    phase_timer #(
        .TICK_DIV    (TD),
        .CNT_W       (CW),
        .RED_TIME    (RT),
        .GREEN_TIME  (GT),
        .YELLOW_TIME (YT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .red       (red),
        .green     (green),
        .yellow    (yellow),
        .clr       (clr),
        .max_r     (max_r),
        .max_g     (max_g),
        .max_y     (max_y),
        .tick      (tick),
        .phase_err (phase_err)
`ifdef PHASE_TIMER_REMAIN_EN
        ,
        .remain    (remain)
`endif
    );

    always #5 clk = ~clk;

    assign obs = {tick, max_r, max_g, max_y, phase_err};

    // Ticks seen since the phase started: one per full TD-cycle period, saturating.
    function automatic int m_count();
        int c;
        if (m_age == 0) return 0;
        c = (m_age - 1) / TD;
        return (c > (1 << CW) - 1) ? (1 << CW) - 1 : c;
    endfunction

    function automatic logic m_legal();
        return (int'(red) + int'(green) + int'(yellow)) == 1;
    endfunction

    function automatic logic [4:0] exp_vec();
        int   c;
        logic ok;
        c  = m_count();
        ok = m_legal() && !clr;
        return {(m_age > 0) && (m_age % TD == 0),
                ok && red    && (c >= RT),
                ok && green  && (c >= GT),
                ok && yellow && (c >= YT),
                m_err != 0};
    endfunction

    function automatic int exp_remain();
        int t;
        if (!m_legal() || clr) return 0;
        t = red ? RT : (green ? GT : YT);
        return (t > m_count()) ? t - m_count() : 0;
    endfunction

    task automatic advance();
        @(posedge clk);
        m_err = (!reset && !m_legal()) ? 1 : 0;
        m_age = (reset || clr) ? 0 : m_age + 1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; red = 1'b1; green = 1'b1; yellow = 1'b0; clr = 1'b0;
        repeat (3) begin
            advance();
            #1;
            e = exp_vec(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL reset_hold: got %b expected %b", obs, e); end
        end
        reset = 1'b0; green = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            e = exp_vec(); n_cmp++;
            if (obs !== 5'b00000) begin n_bad++; $display("FAIL reset_release: got %b expected %b", obs, 5'b00000); end
            advance();
        end
    endtask

    task automatic test_red_expiry();
        int rise;
        rise = -1;
        red = 1'b1; green = 1'b0; yellow = 1'b0; clr = 1'b1;
        #1;
        e = exp_vec(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL red_expiry_clr: got %b expected %b", obs, e); end
        advance();
        clr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            e = exp_vec(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL red_expiry: got %b expected %b at age %0d", obs, e, m_age); end
            if (rise < 0 && max_r === 1'b1) rise = i;
            advance();
        end
        n_cmp++;
        if (rise !== RT * TD + 1) begin n_bad++; $display("FAIL red_rise_cycle: got %0d expected %0d", rise, RT * TD + 1); end
    endtask

    task automatic test_phase_change();
        int rise;
        rise = -1;
        red = 1'b0; green = 1'b1; clr = 1'b1;
        #1;
        n_cmp++;
        if (max_g !== 1'b0) begin n_bad++; $display("FAIL change_gate: max_g got %b expected 0", max_g); end
        advance();
        clr = 1'b0;
        for (int i = 0; i < 25; i++) begin
            #1;
            e = exp_vec(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL phase_change: got %b expected %b at age %0d", obs, e, m_age); end
            if (rise < 0 && max_g === 1'b1) rise = i;
            advance();
        end
        n_cmp++;
        if (rise !== GT * TD + 1) begin n_bad++; $display("FAIL green_rise_cycle: got %0d expected %0d", rise, GT * TD + 1); end
    endtask

    task automatic test_saturation();
        red = 1'b1; green = 1'b0; yellow = 1'b0; clr = 1'b1;
        advance();
        clr = 1'b0;
        for (int i = 0; i < 22 * TD; i++) begin
            #1;
            e = exp_vec(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL saturation: got %b expected %b at age %0d", obs, e, m_age); end
            advance();
        end
        n_cmp++;
        if (max_r !== 1'b1) begin n_bad++; $display("FAIL saturation_hold: max_r got %b expected 1", max_r); end
    endtask

    task automatic test_collision();
        red = 1'b1; green = 1'b0; yellow = 1'b0; clr = 1'b0;
        for (int i = 0; i < 2 * TD && tick !== 1'b1; i++) advance();
        n_cmp++;
        if (tick !== 1'b1) begin n_bad++; $display("FAIL collision_wait: tick got %b expected 1", tick); end
        clr = 1'b1;
        #1;
        e = exp_vec(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL collision_clr: got %b expected %b", obs, e); end
        advance();
        clr = 1'b0;
        for (int k = 0; k <= TD; k++) begin
            #1;
            n_cmp++;
            if (tick !== (k == TD)) begin n_bad++; $display("FAIL collision_tick: k=%0d got %b expected %b", k, tick, (k == TD)); end
            e = exp_vec(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL collision: got %b expected %b at k %0d", obs, e, k); end
            advance();
        end
    endtask

    task automatic test_illegal();
        logic [2:0] bad [2];
        bad[0] = 3'b110;
        bad[1] = 3'b000;
        for (int p = 0; p < 2; p++) begin
            red = 1'b1; green = 1'b0; yellow = 1'b0; clr = 1'b1;
            advance();
            clr = 1'b0;
            repeat (RT * TD + 2) advance();
            {red, green, yellow} = bad[p];
            #1;
            e = exp_vec(); n_cmp++;
            if (obs[3:1] !== 3'b000 || obs !== e) begin n_bad++; $display("FAIL illegal_mask: got %b expected %b", obs, e); end
            advance();
            {red, green, yellow} = 3'b100;
            #1;
            n_cmp++;
            if (phase_err !== 1'b1) begin n_bad++; $display("FAIL illegal_err_set: got %b expected 1", phase_err); end
            e = exp_vec(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL illegal_resume: got %b expected %b", obs, e); end
            advance();
            #1;
            n_cmp++;
            if (phase_err !== 1'b0) begin n_bad++; $display("FAIL illegal_err_clear: got %b expected 0", phase_err); end
            advance();
        end
    endtask

    task automatic test_random();
        int cur;
        int r;
        cur = 0;
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            r = $urandom_range(0, 99);
            if (r < 8) begin
                cur = $urandom_range(0, 2);
                {red, green, yellow} = 3'b100 >> cur;
                clr = 1'b1;
            end else if (r < 12) begin
                {red, green, yellow} = 3'($urandom_range(0, 7));
                clr = ($urandom_range(0, 3) == 0);
            end else begin
                {red, green, yellow} = 3'b100 >> cur;
                clr = ($urandom_range(0, 49) == 0);
            end
            #1;
            e = exp_vec(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL random: got %b expected %b at cycle %0d", obs, e, i); end
`ifdef PHASE_TIMER_REMAIN_EN
            n_cmp++;
            if (int'(remain) !== exp_remain()) begin n_bad++; $display("FAIL remain: got %0d expected %0d", remain, exp_remain()); end
`endif
            advance();
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_red_expiry();
        test_phase_change();
        test_saturation();
        test_collision();
        test_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
